// File: rtl/hwconfig_pkg.sv
// hwconfig_pkg: shared state encoding, slot indices and default IO word-select bits
package hwconfig_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [1:0] SLOT_RAM = 2'd0;
  localparam logic [1:0] SLOT_DEV = 2'd1;
  localparam logic [1:0] SLOT_CPU = 2'd2;

  // Shared with the config-register decoder so both sides agree on the IO map
  localparam logic [31:0] DEF_IO_BASE     = 32'h0040_0000;
  localparam int          DEF_MEMORY_BIT  = 17;
  localparam int          DEF_DEVICES_BIT = 18;
  localparam int          DEF_CPUINFO_BIT = 19;
endpackage

// File: rtl/hwconfig_timeout.sv
// hwconfig_timeout: saturating busy-cycle counter; expired flags the MAX-th enabled cycle
module hwconfig_timeout #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != W'(MAX)) cnt <= cnt + 1'b1;

  assign expired = en && (cnt == W'(MAX - 1));
endmodule

// File: rtl/hwconfig_reader.sv
// hwconfig_reader: IO-bus initiator that latches RAM size, device mask and CPU info.
// HWCONFIG_READER_TIMEOUT_EN enables the per-read busy timeout and the FAIL state.
module hwconfig_reader
  import hwconfig_pkg::*;
#(
  parameter logic [31:0] IO_BASE        = DEF_IO_BASE,
  parameter int          MEMORY_BIT     = DEF_MEMORY_BIT,
  parameter int          DEVICES_BIT    = DEF_DEVICES_BIT,
  parameter int          CPUINFO_BIT    = DEF_CPUINFO_BIT,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [31:0] io_addr,
  output logic        io_rstrb,
  input  logic [31:0] io_rdata,
  input  logic        io_rbusy,
  output logic [31:0] ram_bytes,
  output logic [31:0] devices,
  output logic [15:0] freq_mhz,
  output logic [15:0] counter_width,
  input  logic [4:0]  dev_sel,
  output logic        dev_present,
  output logic        valid,
  output logic        busy,
  output logic        error
);
  state_t     state;
  logic       pending;
  logic [1:0] idx;
  logic       err;
  logic       expired;

  function automatic logic [31:0] addr_of(input logic [1:0] i);
    int b;
    b = (i == SLOT_RAM) ? MEMORY_BIT : (i == SLOT_DEV) ? DEVICES_BIT : CPUINFO_BIT;
    return IO_BASE | (32'd1 << (b + 2));
  endfunction

`ifdef HWCONFIG_READER_TIMEOUT_EN
  hwconfig_timeout #(.MAX(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (state == S_ISSUE),
    .en      (state == S_WAIT && io_rbusy),
    .expired (expired)
  );
  assign error = err;
`else
  logic unused;
  assign expired = 1'b0;
  assign error   = 1'b0;
  assign unused  = ^{err, TIMEOUT_CYCLES};
`endif

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state         <= S_IDLE;
      pending       <= 1'b1;
      idx           <= SLOT_RAM;
      io_addr       <= '0;
      ram_bytes     <= '0;
      devices       <= '0;
      freq_mhz      <= '0;
      counter_width <= '0;
      valid         <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (pending || start) begin
            state   <= S_ISSUE;
            pending <= 1'b0;
            idx     <= SLOT_RAM;
            io_addr <= addr_of(SLOT_RAM);
          end
        S_ISSUE: state <= S_WAIT;
        S_WAIT:
          if (!io_rbusy) begin
            if (idx == SLOT_RAM) ram_bytes <= io_rdata;
            if (idx == SLOT_DEV) devices <= io_rdata;
            if (idx == SLOT_CPU) {freq_mhz, counter_width} <= io_rdata;
            if (idx == SLOT_CPU) state <= S_DONE;
            else begin
              state   <= S_ISSUE;
              idx     <= idx + 2'd1;
              io_addr <= addr_of(idx + 2'd1);
            end
          end else if (expired) begin
            state <= S_FAIL;
            err   <= 1'b1;
          end
        S_DONE, S_FAIL:
          // A restart wipes the previous result so stale data is never seen as current
          if (start) begin
            state         <= S_ISSUE;
            idx           <= SLOT_RAM;
            io_addr       <= addr_of(SLOT_RAM);
            ram_bytes     <= '0;
            devices       <= '0;
            freq_mhz      <= '0;
            counter_width <= '0;
            valid         <= 1'b0;
            err           <= 1'b0;
          end else valid <= (state == S_DONE);
        default: state <= S_IDLE;
      endcase
    end

  assign io_rstrb    = (state == S_ISSUE);
  assign busy        = (state == S_ISSUE) || (state == S_WAIT);
  assign dev_present = devices[dev_sel] & valid;
endmodule

// File: tb/tb_hwconfig_reader.sv
// tb_hwconfig_reader: randomized probes against a target model with per-slot busy latency
module tb_hwconfig_reader;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] io_addr, io_rdata, ram_bytes, devices;
  logic        io_rstrb, io_rbusy;
  logic [15:0] freq_mhz, counter_width;
  logic [4:0]  dev_sel = '0;
  logic        dev_present, valid, busy, error;

  int checks = 0;
  int errors = 0;

  logic [31:0] cfg[3];
  int          bz[3];
  int          tcnt = 0;
  logic [31:0] tdata = '0;
  logic [31:0] strobes[$];

  always #5 clk = ~clk;

  hwconfig_reader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .io_addr       (io_addr),
    .io_rstrb      (io_rstrb),
    .io_rdata      (io_rdata),
    .io_rbusy      (io_rbusy),
    .ram_bytes     (ram_bytes),
    .devices       (devices),
    .freq_mhz      (freq_mhz),
    .counter_width (counter_width),
    .dev_sel       (dev_sel),
    .dev_present   (dev_present),
    .valid         (valid),
    .busy          (busy),
    .error         (error)
  );

  function automatic logic [31:0] slot_addr(input int s);
    return BASE | (32'd1 << (19 + s));
  endfunction

  function automatic int slot_of(input logic [31:0] a);
    for (int s = 0; s < 3; s++) if (a == slot_addr(s)) return s;
    return 3;
  endfunction

  // Target: after each strobe it stays busy bz[slot] cycles, returning junk while busy
  assign io_rbusy = (tcnt != 0);
  assign io_rdata = io_rbusy ? 32'hDEAD_BEEF : tdata;

  always @(posedge clk)
    if (!resetn) tcnt <= 0;
    else if (io_rstrb) begin
      tcnt  <= (slot_of(io_addr) < 3) ? bz[slot_of(io_addr)] : 0;
      tdata <= (slot_of(io_addr) < 3) ? cfg[slot_of(io_addr)] : 32'hBAD0_0000;
    end else if (tcnt != 0) tcnt <= tcnt - 1;

  always @(negedge clk)
    if (resetn && io_rstrb) strobes.push_back(io_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, io_addr, 0);
    check({tag, "_rstrb"}, {31'd0, io_rstrb}, 0);
    check({tag, "_ram"}, ram_bytes, 0);
    check({tag, "_dev"}, devices, 0);
    check({tag, "_cpu"}, {freq_mhz, counter_width}, 0);
    check({tag, "_flags"}, {28'd0, valid, busy, error, dev_present}, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start  = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;
    strobes.delete();
  endtask

  task automatic wait_valid(input string tag, input int exp_edges);
    int n = 0;
    while (!valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, exp_edges);
  endtask

  task automatic check_data(input string tag);
    check({tag, "_ram"}, ram_bytes, cfg[0]);
    check({tag, "_dev"}, devices, cfg[1]);
    check({tag, "_freq"}, {16'd0, freq_mhz}, {16'd0, cfg[2][31:16]});
    check({tag, "_cw"}, {16'd0, counter_width}, {16'd0, cfg[2][15:0]});
    check({tag, "_err"}, {31'd0, error}, 0);
    dev_sel = 5'($urandom);
    #1;
    check({tag, "_present"}, {31'd0, dev_present}, {31'd0, cfg[1][dev_sel]});
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_nstrobe"}, strobes.size(), 3);
    for (int i = 0; i < strobes.size() && i < 3; i++) check({tag, "_saddr"}, strobes[i], slot_addr(i));
    strobes.delete();
  endtask

  task automatic restart(input string tag);
    @(negedge clk);
    start = 1'b1;
    strobes.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_clr_valid"}, {31'd0, valid}, 0);
    check({tag, "_clr_data"}, ram_bytes | devices | {freq_mhz, counter_width}, 0);
    wait_valid({tag, "_edge"}, 7 + bz[0] + bz[1] + bz[2]);
  endtask

  task automatic rand_cfg(input int maxb);
    for (int s = 0; s < 3; s++) begin
      cfg[s] = $urandom;
      bz[s]  = $urandom_range(0, maxb);
    end
  endtask

  initial begin
    cfg[0] = 32'h0002_0000;
    cfg[1] = 32'h0000_01C3;
    cfg[2] = 32'h0032_0020;
    bz[0] = 0; bz[1] = 0; bz[2] = 0;
    do_reset();
    wait_valid("zw_edge", 8);
    check("zw_freq50", {16'd0, freq_mhz}, 50);
    check("zw_cw32", {16'd0, counter_width}, 32);
    check_data("zw");

    bz[1] = 3;
    do_reset();
    wait_valid("busy3_edge", 11);
    check_data("busy3");
    dev_sel = 5'd6;
    #1;
    check("present6", {31'd0, dev_present}, 1);
    dev_sel = 5'd2;
    #1;
    check("present2", {31'd0, dev_present}, 0);

    cfg[0] = 32'h0004_0000;
    restart("rs");
    check_data("rs");

    for (int k = 0; k < 5; k++) begin
      rand_cfg(3);
      restart("rnd");
      check_data("rnd");
    end

    rand_cfg(3);
    do_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid("wstart_edge", 8 + bz[0] + bz[1] + bz[2] - 3);
    check_data("wstart");

    rand_cfg(3);
    cfg[0] = cfg[0] | 32'h1;
    bz[1] = 4;
    do_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    strobes.delete();
    wait_valid("midrst_edge", 8 + bz[0] + bz[1] + bz[2]);
    check_data("midrst");

`ifdef HWCONFIG_READER_TIMEOUT_EN
    rand_cfg(2);
    bz[2] = 1000;
    do_reset();
    begin
      int n = 0;
      while (!error && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("to_edge", n, 1 + (2 + bz[0]) + (2 + bz[1]) + 1 + TO);
    end
    check("to_valid", {31'd0, valid}, 0);
    check("to_busy", {31'd0, busy}, 0);
    check("to_ram", ram_bytes, cfg[0]);
    check("to_dev", devices, cfg[1]);
    check("to_cpu", {freq_mhz, counter_width}, 0);
    bz[2] = 1;
    restart("to_rs");
    check_data("to_rs");
`else
    rand_cfg(2);
    bz[2] = 20;
    restart("long");
    check_data("long");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hwconfig_reader.md
# hwconfig_reader

Bus-initiator that reads the SoC's memory-mapped hardware-configuration words (RAM size, device mask, CPU info) over the IO bus. It runs automatically after reset, or again on request. It latches the three words and exposes them as decoded, stable outputs with a valid flag. It sits beside the CPU on the IO bus arbiter, for boot/debug logic that must learn the build configuration without software.

## Interface
Parameters:
- IO_BASE, 32'h0040_0000, IO page base address
- MEMORY_BIT, 17, one-hot IO word-select bit of the RAM-size word
- DEVICES_BIT, 18, one-hot IO word-select bit of the device-mask word
- CPUINFO_BIT, 19, one-hot IO word-select bit of the CPU-info word
- TIMEOUT_CYCLES, 255, max busy-wait cycles per read (timeout build only)

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle re-probe request
- io_addr  out  32  read address
- io_rstrb  out  1  read strobe, one cycle per read
- io_rdata  in  32  read data
- io_rbusy  in  1  target not ready; data not yet valid
- ram_bytes  out  32  latched RAM-size word
- devices  out  32  latched device mask
- freq_mhz  out  16  CPU-info bits [31:16]
- counter_width  out  16  CPU-info bits [15:0]
- dev_sel  in  5  device-bit index to query
- dev_present  out  1  devices[dev_sel] & valid (combinational)
- valid  out  1  all three words captured
- busy  out  1  probe in progress
- error  out  1  last probe timed out

## Operation
- States: IDLE, ISSUE, WAIT, DONE, FAIL. Slot index idx counts 0..2, in the order RAM, DEVICES, CPUINFO.
- Reset: state IDLE, pending=1, idx=0. All outputs and data registers are 0; io_addr=0.
- IDLE: if pending=1 or start=1, go to ISSUE and clear pending.
- ISSUE: io_rstrb=1 and io_addr = IO_BASE | (1 << (SLOT_BIT+2)). Clear the timeout counter. Go to WAIT.
- WAIT: io_addr holds. io_rstrb=0.
  - If io_rbusy=0, capture io_rdata into slot idx.
  - If idx=2 after the capture, go to DONE; otherwise increment idx and go to ISSUE.
- DONE: valid=1. start=1 goes to ISSUE with idx=0. The restart clears valid, error, ram_bytes, devices, freq_mhz and counter_width.
- FAIL: error=1, valid=0. start=1 restarts exactly as from DONE.
- busy=1 in ISSUE and WAIT only. start is ignored while busy. A start in IDLE is consumed normally.
- io_rstrb and busy are decoded from state. Data outputs are registered.

## Timing
- Each read takes ISSUE (1 cycle) plus WAIT of at least 1 cycle. io_rdata is sampled in the first WAIT cycle that has io_rbusy=0.
- With a zero-wait target, a full probe is 6 cycles after leaving IDLE. valid rises on the 8th rising edge after resetn deasserts (IDLE, then 6 probe cycles, then the DONE entry edge).
- Each additional io_rbusy-high cycle adds one cycle.
- If resetn is asserted mid-probe, everything returns to reset values immediately and the auto-probe reruns after release.
- A start coincident with the DONE-entry edge is ignored, because the state machine is still busy on that edge.

## Configuration
- HWCONFIG_READER_TIMEOUT_EN defined:
  - WAIT counts consecutive io_rbusy=1 cycles.
  - When the count reaches TIMEOUT_CYCLES, the block enters FAIL. The slot being read is not captured, and earlier slots keep their values.
- HWCONFIG_READER_TIMEOUT_EN undefined:
  - WAIT waits indefinitely and FAIL is unreachable.
  - error is tied to 0, and the counter and TIMEOUT_CYCLES are unused.

## Structure
- Package hwconfig_pkg holds:
  - the state enum
  - slot index constants SLOT_RAM=0, SLOT_DEV=1, SLOT_CPU=2
  - default select-bit values shared with the config-register decoder
- One sub-module, hwconfig_timeout: a saturating busy-cycle counter with clear, enable and expired outputs. It is instantiated only under HWCONFIG_READER_TIMEOUT_EN.

## Test plan
- Reset release, zero-wait target returning 32'h0002_0000, 32'h0000_01C3, 32'h0032_0020:
  - exactly 3 io_rstrb pulses, at addresses IO_BASE|(1<<19), IO_BASE|(1<<20), IO_BASE|(1<<21)
  - valid rises on the 8th edge
  - ram_bytes=32'h20000, freq_mhz=50, counter_width=32
- Target holds io_rbusy=1 for 3 cycles on the DEVICES read:
  - capture is delayed 3 cycles and valid rises 3 edges later
  - devices=32'h1C3; dev_sel=6 gives dev_present=1; dev_sel=2 gives dev_present=0
- start pulsed in DONE with a new target value 32'h0004_0000:
  - valid drops the next cycle and the data outputs read 0
  - the probe reruns and ram_bytes=32'h40000
- start pulsed during WAIT:
  - ignored; exactly 3 strobes total for the probe
- Timeout build, TIMEOUT_CYCLES=8, io_rbusy stuck high on the CPUINFO read:
  - FAIL after 8 busy cycles; error=1, valid=0
  - ram_bytes and devices retained; counter_width=0
- resetn asserted mid-WAIT:
  - all outputs 0 immediately
  - a clean auto-probe after release
